// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs for the ALU and LSB, round-robin
// grant, one registered broadcast per cycle to the RS, LSB and ROB.
module cdb_arbiter #(
   parameter int DEPTH = 4,
   parameter int ROB_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             alu_config,
   input  logic [31:0]      alu_val,
   input  logic [ROB_W-1:0] alu_rob_entry,
   input  logic             lsb_config,
   input  logic [31:0]      lsb_val,
   input  logic [ROB_W-1:0] lsb_rob_entry,
   output logic             cdb_config,
   output logic [31:0]      cdb_val,
   output logic [ROB_W-1:0] cdb_rob_entry,
   output logic             alu_full,
   output logic             lsb_full,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_LSB = 1'b1;

   // Index 0 is the ALU, index 1 is the LSB.
   logic [31:0]      q_val [2][DEPTH];
   logic [ROB_W-1:0] q_tag [2][DEPTH];
   logic [PTR_W-1:0] head [2];
   logic [PTR_W-1:0] tail [2];
   logic [CNT_W-1:0] count [2];
   logic             last_grant;

   logic [1:0]       in_cfg;
   logic [31:0]      in_val [2];
   logic [ROB_W-1:0] in_tag [2];
   logic [1:0]       nonempty, cand, pop, push_ok, drop;
   logic             any_cand, win;
   logic [31:0]      win_val;
   logic [ROB_W-1:0] win_tag;

   always_comb begin
      in_cfg    = {lsb_config, alu_config};
      in_val[0] = alu_val;
      in_val[1] = lsb_val;
      in_tag[0] = alu_rob_entry;
      in_tag[1] = lsb_rob_entry;
      nonempty  = '0;
      cand      = '0;
      pop       = '0;
      push_ok   = '0;
      drop      = '0;
      for (int s = 0; s < 2; s++) begin
         nonempty[s] = (count[s] != '0);
         cand[s]     = nonempty[s] | in_cfg[s];
      end
      any_cand = |cand;
      // Under contention the source that did not win last time takes the bus.
      if (cand[0] && cand[1]) win = ~last_grant;
      else                    win = cand[1] ? SRC_LSB : SRC_ALU;
      if (nonempty[win]) begin
         win_val = q_val[win][head[win]];
         win_tag = q_tag[win][head[win]];
      end else begin
         win_val = in_val[win];
         win_tag = in_tag[win];
      end
      for (int s = 0; s < 2; s++) begin
         logic granted, push_req;
         granted    = any_cand && (win == 1'(s));
         pop[s]     = granted && nonempty[s];
         push_req   = in_cfg[s] && !(granted && !nonempty[s]);
         push_ok[s] = push_req && ((count[s] != CNT_MAX) || pop[s]);
         drop[s]    = push_req && (count[s] == CNT_MAX) && !pop[s];
      end
   end

   assign alu_full = (count[0] >= CNT_HIGH);
   assign lsb_full = (count[1] >= CNT_HIGH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_config    <= 1'b0;
         cdb_val       <= '0;
         cdb_rob_entry <= '0;
         last_grant    <= SRC_LSB;
         overflow      <= 1'b0;
         for (int s = 0; s < 2; s++) begin
            head[s]  <= '0;
            tail[s]  <= '0;
            count[s] <= '0;
         end
      end else if (rollback) begin
         cdb_config <= 1'b0;
         last_grant <= SRC_LSB;
         for (int s = 0; s < 2; s++) begin
            head[s]  <= '0;
            tail[s]  <= '0;
            count[s] <= '0;
         end
      end else if (rdy) begin
         cdb_config <= any_cand;
         if (any_cand) begin
            cdb_val       <= win_val;
            cdb_rob_entry <= win_tag;
            last_grant    <= win;
         end
         if (|drop) overflow <= 1'b1;
         for (int s = 0; s < 2; s++) begin
            if (pop[s])     head[s] <= head[s] + PTR_ONE;
            if (push_ok[s]) tail[s] <= tail[s] + PTR_ONE;
            if (push_ok[s] && !pop[s])      count[s] <= count[s] + CNT_ONE;
            else if (pop[s] && !push_ok[s]) count[s] <= count[s] - CNT_ONE;
         end
      end
   end

   // Storage needs no reset: count/pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (!rst && !rollback && rdy) begin
         for (int s = 0; s < 2; s++) begin
            if (push_ok[s]) begin
               q_val[s][tail[s]] <= in_val[s];
               q_tag[s][tail[s]] <= in_tag[s];
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: expected broadcasts are queued as stimulus is
// driven and compared in order whenever the bus carries a new result.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback;
   logic        alu_config, lsb_config;
   logic [31:0] alu_val, lsb_val;
   logic [3:0]  alu_rob_entry, lsb_rob_entry;
   logic        cdb_config;
   logic [31:0] cdb_val;
   logic [3:0]  cdb_rob_entry;
   logic        alu_full, lsb_full, overflow;

   int checks = 0;
   int errors = 0;
   logic [35:0] exp_q[$];
   logic        rdy_at_edge = 1'b0;

   cdb_arbiter #(.DEPTH(4), .ROB_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .alu_config(alu_config), .alu_val(alu_val), .alu_rob_entry(alu_rob_entry),
      .lsb_config(lsb_config), .lsb_val(lsb_val), .lsb_rob_entry(lsb_rob_entry),
      .cdb_config(cdb_config), .cdb_val(cdb_val), .cdb_rob_entry(cdb_rob_entry),
      .alu_full(alu_full), .lsb_full(lsb_full), .overflow(overflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic ac, input logic [31:0] av, input logic [3:0] at,
                         input logic lc, input logic [31:0] lv, input logic [3:0] lt);
      alu_config = ac; alu_val = av; alu_rob_entry = at;
      lsb_config = lc; lsb_val = lv; lsb_rob_entry = lt;
   endtask

   task automatic set_idle();
      set_in(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
      set_idle();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   // scoreboard: only edges where the DUT was allowed to advance produce new results
   always @(posedge clk) rdy_at_edge <= rdy && !rollback;

   always @(negedge clk) begin
      if (!rst && rdy_at_edge && cdb_config) begin
         check("cdb_expected_pending", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0)
            check("cdb_broadcast", {28'd0, cdb_rob_entry, cdb_val}, {28'd0, exp_q.pop_front()});
      end
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_cfg", 64'(cdb_config), 64'd0);
      check("rst_val", 64'(cdb_val), 64'd0);
      check("rst_tag", 64'(cdb_rob_entry), 64'd0);
      check("rst_alu_full", 64'(alu_full), 64'd0);
      check("rst_lsb_full", 64'(lsb_full), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);

      // single result, one-cycle latency
      set_in(1'b1, 32'h0000_002A, 4'd3, 1'b0, 32'h0, 4'h0);
      exp_q.push_back({4'd3, 32'h0000_002A});
      tick();
      set_idle();
      check("t1_cfg", 64'(cdb_config), 64'd1);
      tick();
      check("t1_idle", 64'(cdb_config), 64'd0);

      // contention from reset: ALU first
      do_reset();
      set_in(1'b1, 32'h11, 4'd1, 1'b1, 32'h22, 4'd2);
      exp_q.push_back({4'd1, 32'h11});
      exp_q.push_back({4'd2, 32'h22});
      tick();
      set_idle();
      check("t2_first_val", 64'(cdb_val), 64'h11);
      tick();
      check("t2_second_val", 64'(cdb_val), 64'h22);
      tick();
      check("t2_idle", 64'(cdb_config), 64'd0);
      check("t2_lsb_full", 64'(lsb_full), 64'd0);
      wait_drain("t2_drain");

      // sustained contention, 4 cycles
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 32'h100 + i, 4'(i), 1'b1, 32'h200 + i, 4'(8 + i));
         exp_q.push_back({4'(i), 32'h100 + i});
         exp_q.push_back({4'(8 + i), 32'h200 + i});
         tick();
      end
      set_idle();
      wait_drain("t3_drain");
      check("t3_overflow", 64'(overflow), 64'd0);
      check("t3_lsb_full", 64'(lsb_full), 64'd0);

      // overflow: both fire continuously, LSB queue saturates
      do_reset();
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({4'(k), 32'hA000 + k});
         exp_q.push_back({4'(k), 32'hB000 + k});
      end
      exp_q.push_back({4'd8, 32'hA008});
      for (int k = 0; k < 9; k++) begin
         set_in(1'b1, 32'hA000 + k, 4'(k), 1'b1, 32'hB000 + k, 4'(k));
         tick();
         if (k == 3) check("t4_lsb_full_cnt2", 64'(lsb_full), 64'd0);
         if (k == 4) check("t4_lsb_full_cnt3", 64'(lsb_full), 64'd1);
         if (k == 5) check("t4_alu_full_cnt3", 64'(alu_full), 64'd1);
         if (k == 7) check("t4_no_overflow_yet", 64'(overflow), 64'd0);
         if (k == 8) check("t4_overflow", 64'(overflow), 64'd1);
      end
      set_idle();
      wait_drain("t4_drain");
      check("t4_overflow_sticky", 64'(overflow), 64'd1);
      rollback = 1'b1;
      tick();
      rollback = 1'b0;
      check("t4_overflow_after_rollback", 64'(overflow), 64'd1);
      do_reset();
      check("t4_overflow_after_rst", 64'(overflow), 64'd0);

      // rollback mid-drain
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({4'(k), 32'hC000 + k});
         exp_q.push_back({4'(k), 32'hD000 + k});
      end
      for (int k = 0; k < 6; k++) begin
         set_in(1'b1, 32'hC000 + k, 4'(k), 1'b1, 32'hD000 + k, 4'(k));
         tick();
      end
      check("t5_alu_full_before", 64'(alu_full), 64'd1);
      check("t5_lsb_full_before", 64'(lsb_full), 64'd1);
      rollback = 1'b1;
      set_in(1'b0, 32'h0, 4'h0, 1'b1, 32'hDEAD, 4'd7);
      tick();
      rollback = 1'b0;
      set_idle();
      check("t5_cfg", 64'(cdb_config), 64'd0);
      check("t5_alu_full", 64'(alu_full), 64'd0);
      check("t5_lsb_full", 64'(lsb_full), 64'd0);
      check("t5_pending", 64'(exp_q.size()), 64'd0);
      repeat (4) tick();
      check("t5_still_idle", 64'(cdb_config), 64'd0);

      // rdy low freezes everything
      do_reset();
      set_in(1'b1, 32'h55, 4'd5, 1'b1, 32'h66, 4'd6);
      exp_q.push_back({4'd5, 32'h55});
      exp_q.push_back({4'd6, 32'h66});
      tick();
      rdy = 1'b0;
      set_in(1'b1, 32'hBAD0, 4'd9, 1'b1, 32'hBAD1, 4'd10);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_hold_cfg", 64'(cdb_config), 64'd1);
         check("t6_hold_val", 64'(cdb_val), 64'h55);
         check("t6_hold_tag", 64'(cdb_rob_entry), 64'd5);
      end
      rdy = 1'b1;
      set_idle();
      tick();
      check("t6_resume_val", 64'(cdb_val), 64'h66);
      tick();
      check("t6_resume_idle", 64'(cdb_config), 64'd0);
      wait_drain("t6_drain");

      // asynchronous reset between edges
      set_in(1'b1, 32'h77, 4'd4, 1'b0, 32'h0, 4'h0);
      exp_q.push_back({4'd4, 32'h77});
      tick();
      set_idle();
      #5;
      rst = 1'b1;
      #1;
      check("t7_async_cfg", 64'(cdb_config), 64'd0);
      check("t7_async_val", 64'(cdb_val), 64'd0);
      #1 rst = 1'b0;
      tick();
      check("t7_pending", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
